// File: rtl/lsu_bus_if_if.sv
// Data-bus bundle between the load/store unit (master) and the core data port (slave).
// Read address, read data, write request and write response channels, each valid/ready.
interface lsu_bus_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  dr_addr_valid;
    logic                  dr_addr_ready;
    logic [ADDR_WIDTH-1:0] dr_addr;
    logic                  dr_data_valid;
    logic                  dr_data_ready;
    logic [DATA_WIDTH-1:0] dr_data;
    logic                  dw_valid;
    logic                  dw_ready;
    logic [ADDR_WIDTH-1:0] dw_addr;
    logic [DATA_WIDTH-1:0] dw_data;
    logic [STRB_WIDTH-1:0] dw_strobe;
    logic                  dw_resp_valid;
    logic                  dw_resp_ready;

    modport master (
        output dr_addr_valid, dr_addr, dr_data_ready,
        output dw_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        input  dw_ready, dw_resp_valid
    );

    modport slave (
        input  dr_addr_valid, dr_addr, dr_data_ready,
        input  dw_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        output dw_ready, dw_resp_valid
    );
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store unit: one valid/ready bus transaction per load_data/store_data pulse, with lane
// steering, strobes and load extension. Optional macro MISALIGNED_TRAP_EN adds the misaligned trap.
//
// state   | meaning
// IDLE    | waiting for a load_data / store_data pulse
// RD_ADDR | dr_addr_valid high, waiting for dr_addr_ready
// RD_DATA | dr_data_ready high, waiting for dr_data_valid
// WR_REQ  | dw_valid high with address/data/strobe, waiting for dw_ready
// WR_RESP | dw_resp_ready high, waiting for dw_resp_valid
// DONE    | data_valid pulse, back to IDLE
module lsu_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_data,
    input  logic                  store_data,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_din,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] load_dout,
`ifdef MISALIGNED_TRAP_EN
    output logic                  misaligned,
`endif
    lsu_bus_if_if.master          bus
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("lsu_bus_if supports DATA_WIDTH = 32 only");
    end

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE, SZ_HALF, SZ_WORD
    } size_t;

    state_t                state;
    logic [1:0]            a_lane;
    logic [2:0]            a_f3;
    logic                  dr_addr_valid_q;
    logic [ADDR_WIDTH-1:0] dr_addr_q;
    logic                  dr_data_ready_q;
    logic                  dw_valid_q;
    logic [ADDR_WIDTH-1:0] dw_addr_q;
    logic [DATA_WIDTH-1:0] dw_data_q;
    logic [STRB_WIDTH-1:0] dw_strobe_q;
    logic                  dw_resp_ready_q;
`ifdef MISALIGNED_TRAP_EN
    logic                  misaligned_q;
`endif

    // Undefined width codes fall through to word accesses.
    function automatic size_t access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: access_size = SZ_BYTE;
            3'b001, 3'b101: access_size = SZ_HALF;
            default:        access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'b0, b};
            3'b101:  extend_load = {16'b0, h};
            default: extend_load = w;
        endcase
    endfunction

    function automatic logic [31:0] steer_store(input logic [31:0] din, input logic [2:0] f3);
        case (access_size(f3))
            SZ_BYTE: steer_store = {4{din[7:0]}};
            SZ_HALF: steer_store = {2{din[15:0]}};
            default: steer_store = din;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        case (access_size(f3))
            SZ_BYTE: store_strobe = 4'b0001 << lane;
            SZ_HALF: store_strobe = lane[1] ? 4'b1100 : 4'b0011;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

`ifdef MISALIGNED_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (access_size(f3))
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            a_lane          <= '0;
            a_f3            <= '0;
            data_valid      <= 1'b0;
            load_dout       <= '0;
            dr_addr_valid_q <= 1'b0;
            dr_addr_q       <= '0;
            dr_data_ready_q <= 1'b0;
            dw_valid_q      <= 1'b0;
            dw_addr_q       <= '0;
            dw_data_q       <= '0;
            dw_strobe_q     <= '0;
            dw_resp_ready_q <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
            misaligned_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_data || store_data) begin
                        a_lane <= addr[1:0];
                        a_f3   <= funct3;
                    end
`ifdef MISALIGNED_TRAP_EN
                    if ((load_data || store_data) && is_misaligned(funct3, addr[1:0])) begin
                        data_valid   <= 1'b1;
                        misaligned_q <= 1'b1;
                        state        <= DONE;
                    end else
`endif
                    // Load has priority; a simultaneous store pulse is dropped.
                    if (load_data) begin
                        dr_addr_valid_q <= 1'b1;
                        dr_addr_q       <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        state           <= RD_ADDR;
                    end else if (store_data) begin
                        dw_valid_q  <= 1'b1;
                        dw_addr_q   <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        dw_data_q   <= steer_store(store_din, funct3);
                        dw_strobe_q <= store_strobe(funct3, addr[1:0]);
                        state       <= WR_REQ;
                    end
                end
                RD_ADDR: begin
                    if (bus.dr_addr_ready) begin
                        dr_addr_valid_q <= 1'b0;
                        dr_data_ready_q <= 1'b1;
                        state           <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.dr_data_valid) begin
                        dr_data_ready_q <= 1'b0;
                        load_dout       <= extend_load(bus.dr_data, a_f3, a_lane);
                        data_valid      <= 1'b1;
                        state           <= DONE;
                    end
                end
                WR_REQ: begin
                    if (bus.dw_ready) begin
                        dw_valid_q      <= 1'b0;
                        dw_resp_ready_q <= 1'b1;
                        state           <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.dw_resp_valid) begin
                        dw_resp_ready_q <= 1'b0;
                        data_valid      <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    data_valid   <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
                    misaligned_q <= 1'b0;
`endif
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dr_addr_valid = dr_addr_valid_q;
    assign bus.dr_addr       = dr_addr_q;
    assign bus.dr_data_ready = dr_data_ready_q;
    assign bus.dw_valid      = dw_valid_q;
    assign bus.dw_addr       = dw_addr_q;
    assign bus.dw_data       = dw_data_q;
    assign bus.dw_strobe     = dw_strobe_q;
    assign bus.dw_resp_ready = dw_resp_ready_q;
`ifdef MISALIGNED_TRAP_EN
    assign misaligned        = misaligned_q;
`endif

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: the bench plays the bus slave and checks against hand-computed values.
module tb_lsu_bus_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_data;
    logic        store_data;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_din;
    logic        data_valid;
    logic [31:0] load_dout;
`ifdef MISALIGNED_TRAP_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_bus_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lsu_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .store_data (store_data),
        .funct3     (funct3),
        .addr       (addr),
        .store_din  (store_din),
        .data_valid (data_valid),
        .load_dout  (load_dout),
`ifdef MISALIGNED_TRAP_EN
        .misaligned (misaligned),
`endif
        .bus        (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait slave; returns the value seen on dr_addr in the request cycle and the latency.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                            output logic [31:0] dout, output logic [31:0] raddr, output int lat);
        bus.dr_addr_ready = 1'b1;
        bus.dr_data_valid = 1'b1;
        bus.dr_data       = word;
        funct3    = f3;
        addr      = a;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        raddr = bus.dr_addr;
        lat = 1;
        while (data_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        dout = load_dout;
        tick();
        bus.dr_data_valid = 1'b0;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] din,
                             output logic [31:0] waddr, output logic [31:0] wdata,
                             output logic [3:0] wstrb, output int lat);
        bus.dw_ready      = 1'b1;
        bus.dw_resp_valid = 1'b1;
        funct3     = f3;
        addr       = a;
        store_din  = din;
        store_data = 1'b1;
        tick();
        store_data = 1'b0;
        waddr = bus.dw_addr;
        wdata = bus.dw_data;
        wstrb = bus.dw_strobe;
        lat = 1;
        while (data_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        bus.dw_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({bus.dr_addr_valid, bus.dr_data_ready, bus.dw_valid, bus.dw_resp_ready, data_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.dr_addr_valid, bus.dr_data_ready, bus.dw_valid, bus.dw_resp_ready, data_valid});
        end
        checks++;
        if ({load_dout, bus.dr_addr, bus.dw_addr, bus.dw_data} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: load_dout=%h dr_addr=%h dw_addr=%h dw_data=%h expected all 0",
                     load_dout, bus.dr_addr, bus.dw_addr, bus.dw_data);
        end
        checks++;
        if (bus.dw_strobe !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobe: got %b expected 0000", bus.dw_strobe);
        end
`ifdef MISALIGNED_TRAP_EN
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_misaligned: got %b expected 0", misaligned);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_loads();
        logic [31:0] dout;
        logic [31:0] raddr;
        int lat;
        run_load(3'b000, 32'h103, 32'h80FF1234, dout, raddr, lat);
        checks++;
        if (raddr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", raddr); end
        checks++;
        if (dout !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", dout); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", lat); end
        checks++;
        if (data_valid !== 1'b0 || load_dout !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_hold: data_valid=%b load_dout=%h expected 0 ffffff80", data_valid, load_dout);
        end

        run_load(3'b101, 32'h202, 32'hABCD1234, dout, raddr, lat);
        checks++;
        if (dout !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_data: got %h expected 0000abcd", dout); end
        run_load(3'b001, 32'h202, 32'hABCD1234, dout, raddr, lat);
        checks++;
        if (dout !== 32'hFFFFABCD) begin errors++; $display("FAIL lh_hi: got %h expected ffffabcd", dout); end
        run_load(3'b001, 32'h200, 32'hABCD1234, dout, raddr, lat);
        checks++;
        if (dout !== 32'h00001234) begin errors++; $display("FAIL lh_lo: got %h expected 00001234", dout); end
        run_load(3'b100, 32'h101, 32'h0000AB00, dout, raddr, lat);
        checks++;
        if (dout !== 32'h000000AB) begin errors++; $display("FAIL lbu_data: got %h expected 000000ab", dout); end
        run_load(3'b011, 32'h10, 32'h89ABCDEF, dout, raddr, lat);
        checks++;
        if (dout !== 32'h89ABCDEF || raddr !== 32'h10) begin
            errors++;
            $display("FAIL undef_f3: data=%h addr=%h expected 89abcdef 00000010", dout, raddr);
        end
    endtask

    task automatic test_stores();
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int lat;
        run_store(3'b001, 32'h202, 32'h1234ABCD, waddr, wdata, wstrb, lat);
        checks++;
        if (waddr !== 32'h200 || wdata !== 32'hABCDABCD || wstrb !== 4'b1100) begin
            errors++;
            $display("FAIL sh: addr=%h data=%h strb=%b expected 00000200 abcdabcd 1100", waddr, wdata, wstrb);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        run_store(3'b000, 32'h101, 32'h000000EF, waddr, wdata, wstrb, lat);
        checks++;
        if (waddr !== 32'h100 || wdata !== 32'hEFEFEFEF || wstrb !== 4'b0010) begin
            errors++;
            $display("FAIL sb: addr=%h data=%h strb=%b expected 00000100 efefefef 0010", waddr, wdata, wstrb);
        end
        run_store(3'b010, 32'h20C, 32'hDEADBEEF, waddr, wdata, wstrb, lat);
        checks++;
        if (waddr !== 32'h20C || wdata !== 32'hDEADBEEF || wstrb !== 4'b1111) begin
            errors++;
            $display("FAIL sw: addr=%h data=%h strb=%b expected 0000020c deadbeef 1111", waddr, wdata, wstrb);
        end
    endtask

    task automatic test_both_pulses();
        int n;
        logic saw_dw;
        bus.dr_addr_ready = 1'b0;
        bus.dw_ready      = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h40;
        store_din  = 32'h77777777;
        load_data  = 1'b1;
        store_data = 1'b1;
        tick();
        load_data  = 1'b0;
        store_data = 1'b0;
        checks++;
        if (bus.dr_addr_valid !== 1'b1 || bus.dw_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_pulses: dr_addr_valid=%b dw_valid=%b expected 1 0", bus.dr_addr_valid, bus.dw_valid);
        end
        bus.dr_addr_ready = 1'b1;
        bus.dr_data_valid = 1'b1;
        bus.dr_data       = 32'h00000055;
        saw_dw = 1'b0;
        n = 0;
        while (data_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (bus.dw_valid === 1'b1) saw_dw = 1'b1;
        end
        checks++;
        if (load_dout !== 32'h55 || saw_dw !== 1'b0 || n >= 20) begin
            errors++;
            $display("FAIL both_pulses_done: load_dout=%h dw_seen=%b cycles=%0d expected 00000055 0 <20",
                     load_dout, saw_dw, n);
        end
        tick();
        bus.dr_data_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int pulses;
        logic addr_ok;
        logic stray;
        bus.dr_addr_ready = 1'b0;
        bus.dr_data_valid = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h30C;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.dr_addr_valid !== 1'b1 || bus.dr_addr !== 32'h30C) addr_ok = 1'b0;
            if (i == 2) begin
                load_data = 1'b1;
                addr      = 32'h444;
            end else begin
                load_data = 1'b0;
            end
            tick();
        end
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_addr_hold: valid=%b addr=%h expected 1 0000030c", bus.dr_addr_valid, bus.dr_addr);
        end
        bus.dr_addr_ready = 1'b1;
        tick();
        bus.dr_addr_ready = 1'b0;
        checks++;
        if (bus.dr_addr_valid !== 1'b0 || bus.dr_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_rd_data: dr_addr_valid=%b dr_data_ready=%b expected 0 1",
                     bus.dr_addr_valid, bus.dr_data_ready);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (data_valid === 1'b1) pulses++;
            tick();
        end
        bus.dr_data_valid = 1'b1;
        bus.dr_data       = 32'h11223344;
        tick();
        bus.dr_data_valid = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || load_dout !== 32'h11223344 || pulses != 0) begin
            errors++;
            $display("FAIL bp_done: data_valid=%b load_dout=%h early=%0d expected 1 11223344 0",
                     data_valid, load_dout, pulses);
        end
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_valid === 1'b1 || bus.dr_addr_valid === 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored_pulse: activity=%b expected 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dout;
        logic [31:0] raddr;
        int lat;
        int seen;
        bus.dw_ready      = 1'b1;
        bus.dw_resp_valid = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h50;
        store_din  = 32'hA5A5A5A5;
        store_data = 1'b1;
        tick();
        store_data = 1'b0;
        tick();
        bus.dw_ready = 1'b0;
        checks++;
        if (bus.dw_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wr_resp: dw_resp_ready=%b expected 1", bus.dw_resp_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.dw_valid, bus.dw_resp_ready, data_valid} !== 3'b000 || bus.dw_strobe !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: dw_valid/resp_ready/data_valid=%b strobe=%b expected 000 0000",
                     {bus.dw_valid, bus.dw_resp_ready, data_valid}, bus.dw_strobe);
        end
        bus.dw_resp_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data_valid === 1'b1) seen++;
        end
        bus.dw_resp_valid = 1'b0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_no_valid: pulses=%0d expected 0", seen); end
        run_load(3'b100, 32'h1, 32'h0000AB00, dout, raddr, lat);
        checks++;
        if (dout !== 32'h000000AB || lat != 3) begin
            errors++;
            $display("FAIL rst_mid_next_load: data=%h latency=%0d expected 000000ab 3", dout, lat);
        end
    endtask

    task automatic test_misaligned();
`ifdef MISALIGNED_TRAP_EN
        bus.dr_addr_ready = 1'b1;
        bus.dr_data_valid = 1'b1;
        bus.dr_data       = 32'hCAFEF00D;
        funct3    = 3'b010;
        addr      = 32'h102;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || misaligned !== 1'b1 || bus.dr_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse: data_valid=%b misaligned=%b dr_addr_valid=%b expected 1 1 0",
                     data_valid, misaligned, bus.dr_addr_valid);
        end
        checks++;
        if (load_dout !== 32'h000000AB) begin
            errors++;
            $display("FAIL trap_dout: got %h expected 000000ab", load_dout);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0 || misaligned !== 1'b0 || bus.dr_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_after: data_valid=%b misaligned=%b dr_addr_valid=%b expected 0 0 0",
                     data_valid, misaligned, bus.dr_addr_valid);
        end
        bus.dr_data_valid = 1'b0;
`else
        logic [31:0] dout;
        logic [31:0] raddr;
        int lat;
        run_load(3'b010, 32'h102, 32'hCAFEF00D, dout, raddr, lat);
        checks++;
        if (raddr !== 32'h100 || dout !== 32'hCAFEF00D || lat != 3) begin
            errors++;
            $display("FAIL misaligned_lw: addr=%h data=%h latency=%0d expected 00000100 cafef00d 3",
                     raddr, dout, lat);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b1;
        load_data         = 1'b0;
        store_data        = 1'b0;
        funct3            = 3'b000;
        addr              = 32'h0;
        store_din         = 32'h0;
        bus.dr_addr_ready = 1'b0;
        bus.dr_data_valid = 1'b0;
        bus.dr_data       = 32'h0;
        bus.dw_ready      = 1'b0;
        bus.dw_resp_valid = 1'b0;
        test_reset();
        test_loads();
        test_stores();
        test_both_pulses();
        test_backpressure();
        test_reset_mid();
        test_misaligned();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
